rv_multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM that sequences the shared-bus RV32 datapath: one instruction per start/done handshake.
- Drives every datapath control strobe: register loads, bus source enables, register file and memory write enables, ALU opcode and immediate select.
- Owns the program counter and drives it onto the bus through a new pc_en source.
- Reads the latched instruction word and the ALU zero flag back from the datapath.

---
 rtl/rv_multicycle_ctrl_if.sv | 46 ++++
 rtl/rv_multicycle_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_rv_multicycle_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/rv_multicycle_ctrl_if.sv
// Control/status bundle between the multi-cycle RV32 controller (master) and its shared-bus datapath (slave).
// RV_CTRL_INSTR_CNT_EN adds the retired-instruction count to the bundle.
interface rv_multicycle_ctrl_if #(parameter int PC_WIDTH = 32);
  logic                start;
  logic [31:0]         ir;
  logic                zero;
  logic                busy;
  logic                done;
  logic                illegal;
  logic [PC_WIDTH-1:0] pc;
  logic                pc_en;
  logic                lda;
  logic                ldb;
  logic                ldma;
  logic                ldiR;
  logic [1:0]          reg_sel;
  logic                reg_en;
  logic                reg_we;
  logic                mem_en;
  logic                mem_we;
  logic                alu_en;
  logic                IMM_en;
  logic [3:0]          ALUControl;
  logic [1:0]          ExtendSign_sel;
`ifdef RV_CTRL_INSTR_CNT_EN
  logic [31:0]         retired;
`endif

  modport master (
    input  start, ir, zero,
    output busy, done, illegal, pc, pc_en, lda, ldb, ldma, ldiR, reg_sel,
           reg_en, reg_we, mem_en, mem_we, alu_en, IMM_en, ALUControl, ExtendSign_sel
`ifdef RV_CTRL_INSTR_CNT_EN
    , output retired
`endif
  );

  modport slave (
    output start, ir, zero,
    input  busy, done, illegal, pc, pc_en, lda, ldb, ldma, ldiR, reg_sel,
           reg_en, reg_we, mem_en, mem_we, alu_en, IMM_en, ALUControl, ExtendSign_sel
`ifdef RV_CTRL_INSTR_CNT_EN
    , input retired
`endif
  );
endinterface

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle sequencer for the shared-bus RV32 datapath; owns the PC, one instruction per start/done.
// Optional RV_CTRL_INSTR_CNT_EN: counts legally completed instructions on dp.retired.
module rv_multicycle_ctrl #(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int                  PC_STEP  = 4,
  parameter int                  MEM_WAIT = 0
) (
  input logic                  clk,
  input logic                  rst,
  rv_multicycle_ctrl_if.master dp
);
  typedef enum logic [3:0] {
    S_IDLE, S_F_MA, S_F_IR, S_DEC, S_RD_A, S_RD_B,
    S_IMM_B, S_WB, S_ADDR, S_LD_WB, S_ST, S_BR
  } state_e;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [3:0]          wait_q, wait_d;
  logic                done_q, done_d;
  logic                ill_q, ill_d;

  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic                is_r, is_i, is_lw, is_sw, is_br;
  logic [3:0]          alu_op;
  logic                alu_ok, legal, taken, wait_done;
  logic [12:0]         bimm;
  logic [PC_WIDTH-1:0] boff, pc_inc;
  logic                fin;

  logic       pc_en, lda, ldb, ldma, ldiR, reg_en, reg_we, mem_en, mem_we, alu_en, imm_en;
  logic [1:0] reg_sel, ext_sel;
  logic [3:0] alu_ctl;

  // The IR register holds the word for the whole instruction, so decode stays combinational.
  assign opcode    = dp.ir[6:0];
  assign funct3    = dp.ir[14:12];
  assign is_r      = (opcode == OP_R);
  assign is_i      = (opcode == OP_I);
  assign is_lw     = (opcode == OP_LW);
  assign is_sw     = (opcode == OP_SW);
  assign is_br     = (opcode == OP_BR);
  assign legal     = is_lw | is_sw | is_br | ((is_r | is_i) & alu_ok);
  assign bimm      = {dp.ir[31], dp.ir[7], dp.ir[30:25], dp.ir[11:8], 1'b0};
  assign boff      = PC_WIDTH'($signed(bimm));
  assign taken     = ((funct3 == 3'b000) & dp.zero) | ((funct3 == 3'b001) & ~dp.zero);
  assign wait_done = (wait_q == 4'(MEM_WAIT));

  always_comb begin
    alu_op = ALU_ADD;
    alu_ok = 1'b1;
    case (funct3)
      3'b000:  alu_op = (is_r && dp.ir[30]) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_op = ALU_AND;
      3'b110:  alu_op = ALU_OR;
      3'b010:  alu_op = ALU_SLT;
      default: alu_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      wait_q  <= '0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wait_q  <= wait_d;
      done_q  <= done_d;
      ill_q   <= ill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wait_d  = wait_q;
    done_d  = 1'b0;
    ill_d   = 1'b0;
    fin     = 1'b0;
    pc_inc  = PC_WIDTH'(PC_STEP);
    pc_en = 1'b0; lda = 1'b0; ldb = 1'b0; ldma = 1'b0; ldiR = 1'b0;
    reg_en = 1'b0; reg_we = 1'b0; mem_en = 1'b0; mem_we = 1'b0;
    alu_en = 1'b0; imm_en = 1'b0;
    reg_sel = 2'd0; ext_sel = 2'b00; alu_ctl = ALU_AND;
    case (state_q)
      S_IDLE: if (dp.start) state_d = S_F_MA;
      S_F_MA: begin
        pc_en = 1'b1; ldma = 1'b1;
        state_d = S_F_IR;
      end
      S_F_IR: begin
        mem_en = 1'b1; ldiR = 1'b1;
        if (wait_done) begin wait_d = '0; state_d = S_DEC; end
        else wait_d = wait_q + 4'd1;
      end
      S_DEC: begin
        if (legal) state_d = S_RD_A;
        else begin state_d = S_IDLE; done_d = 1'b1; ill_d = 1'b1; end
      end
      S_RD_A: begin
        reg_sel = 2'd0; reg_en = 1'b1; lda = 1'b1;
        state_d = (is_r | is_br) ? S_RD_B : S_IMM_B;
      end
      S_RD_B: begin
        reg_sel = 2'd1; reg_en = 1'b1; ldb = 1'b1;
        state_d = is_br ? S_BR : S_WB;
      end
      S_IMM_B: begin
        imm_en = 1'b1; ldb = 1'b1;
        ext_sel = is_sw ? 2'b01 : 2'b00;
        state_d = (is_lw | is_sw) ? S_ADDR : S_WB;
      end
      S_WB: begin
        alu_en = 1'b1; alu_ctl = alu_op; reg_sel = 2'd2; reg_en = 1'b1; reg_we = 1'b1;
        fin = 1'b1;
      end
      S_ADDR: begin
        alu_en = 1'b1; alu_ctl = ALU_ADD; ldma = 1'b1;
        state_d = is_lw ? S_LD_WB : S_ST;
      end
      S_LD_WB: begin
        mem_en = 1'b1; reg_sel = 2'd2; reg_en = 1'b1; reg_we = 1'b1;
        if (wait_done) begin wait_d = '0; fin = 1'b1; end
        else wait_d = wait_q + 4'd1;
      end
      S_ST: begin
        reg_sel = 2'd1; reg_en = 1'b1; mem_en = 1'b1; mem_we = 1'b1;
        if (wait_done) begin wait_d = '0; fin = 1'b1; end
        else wait_d = wait_q + 4'd1;
      end
      S_BR: begin
        alu_en = 1'b1; alu_ctl = ALU_SUB;
        if (taken) pc_inc = boff;
        fin = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // Every legal path ends here: advance the PC and report completion from IDLE.
    if (fin) begin
      state_d = S_IDLE;
      done_d  = 1'b1;
      pc_d    = pc_q + pc_inc;
    end
  end

`ifdef RV_CTRL_INSTR_CNT_EN
  logic [31:0] ret_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  ret_q <= '0;
    else if (done_d && !ill_d) ret_q <= ret_q + 32'd1;
  end
  assign dp.retired = ret_q;
`endif

  assign dp.busy           = (state_q != S_IDLE);
  assign dp.done           = done_q;
  assign dp.illegal        = ill_q;
  assign dp.pc             = pc_q;
  assign dp.pc_en          = pc_en;
  assign dp.lda            = lda;
  assign dp.ldb            = ldb;
  assign dp.ldma           = ldma;
  assign dp.ldiR           = ldiR;
  assign dp.reg_sel        = reg_sel;
  assign dp.reg_en         = reg_en;
  assign dp.reg_we         = reg_we;
  assign dp.mem_en         = mem_en;
  assign dp.mem_we         = mem_we;
  assign dp.alu_en         = alu_en;
  assign dp.IMM_en         = imm_en;
  assign dp.ALUControl     = alu_ctl;
  assign dp.ExtendSign_sel = ext_sel;
endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Scoreboard bench for rv_multicycle_ctrl: stimulus pushes expected outcomes, a negedge monitor checks them.
module tb_rv_multicycle_ctrl;
  localparam int MW  = 2;
  localparam int PCW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv_multicycle_ctrl_if #(.PC_WIDTH(PCW)) dp();
  rv_multicycle_ctrl #(.PC_WIDTH(PCW), .RESET_PC(32'h0), .PC_STEP(4), .MEM_WAIT(MW))
    dut (.clk(clk), .rst(rst), .dp(dp));

  typedef struct {
    string       path;
    int          lat;
    logic [31:0] pc;
    logic        ill;
    int          acc;
    logic [31:0] ret;
  } exp_t;

  exp_t        q[$];
  int          checks = 0, errors = 0, cyc = 0;
  logic [31:0] mpc = 32'h0, mret = 32'h0;
  string       trace = "";

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: expected per-cycle activity (one token per busy cycle), next PC and legality.
  function automatic void model(input logic [31:0] ir, input logic z, input logic [31:0] pc_in,
                                output string path, output logic [31:0] pc_out, output logic ill);
    logic [6:0]  op;
    logic [2:0]  f3;
    int          alu;
    logic [31:0] off;
    string       tail;
    op = ir[6:0];
    f3 = ir[14:12];
    alu = -1;
    case (f3)
      3'd0: alu = (op == 7'b0110011 && ir[30]) ? 6 : 2;
      3'd7: alu = 0;
      3'd6: alu = 1;
      3'd2: alu = 7;
      default: alu = -1;
    endcase
    path = "F_MA ";
    for (int k = 0; k <= MW; k++) path = {path, "F_IR "};
    path = {path, "DEC "};
    ill = 1'b0;
    pc_out = pc_in + 32'd4;
    tail = "";
    if ((op == 7'b0110011 || op == 7'b0010011) && alu >= 0)
      path = {path, "RD_A ", (op == 7'b0110011) ? "RD_B " : "IMM0 ", $sformatf("WB%0h ", alu)};
    else if (op == 7'b0000011) begin
      for (int k = 0; k <= MW; k++) tail = {tail, "LD_WB "};
      path = {path, "RD_A IMM0 ADDR2 ", tail};
    end else if (op == 7'b0100011) begin
      for (int k = 0; k <= MW; k++) tail = {tail, "ST "};
      path = {path, "RD_A IMM1 ADDR2 ", tail};
    end else if (op == 7'b1100011) begin
      path = {path, "RD_A RD_B BR6 "};
      off = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      if ((f3 == 3'd0 && z) || (f3 == 3'd1 && !z)) pc_out = pc_in + off;
    end else ill = 1'b1;
    if (ill || ((op == 7'b0110011 || op == 7'b0010011) && alu < 0)) begin
      ill = 1'b1;
      pc_out = pc_in;
    end
  endfunction

  function automatic string cls();
    logic [12:0] v;
    logic        clean;
    string       s;
    v = {dp.pc_en, dp.lda, dp.ldb, dp.ldma, dp.ldiR, dp.reg_en, dp.reg_we,
         dp.mem_en, dp.mem_we, dp.alu_en, dp.IMM_en, dp.reg_sel};
    clean = (dp.ALUControl == 4'd0) && (dp.ExtendSign_sel == 2'd0);
    case (v)
      13'b1001000000000: s = clean ? "F_MA" : "F_MA!";
      13'b0000100100000: s = clean ? "F_IR" : "F_IR!";
      13'b0000000000000: s = clean ? "DEC" : "DEC!";
      13'b0100010000000: s = clean ? "RD_A" : "RD_A!";
      13'b0010010000001: s = clean ? "RD_B" : "RD_B!";
      13'b0010000000100: s = (dp.ALUControl == 4'd0) ? $sformatf("IMM%0d", dp.ExtendSign_sel) : "IMM!";
      13'b0000011001010: s = (dp.ExtendSign_sel == 2'd0) ? $sformatf("WB%0h", dp.ALUControl) : "WB!";
      13'b0001000001000: s = (dp.ExtendSign_sel == 2'd0) ? $sformatf("ADDR%0h", dp.ALUControl) : "ADDR!";
      13'b0000011100010: s = clean ? "LD_WB" : "LD_WB!";
      13'b0000010110001: s = clean ? "ST" : "ST!";
      13'b0000000001000: s = (dp.ExtendSign_sel == 2'd0) ? $sformatf("BR%0h", dp.ALUControl) : "BR!";
      default:           s = $sformatf("BAD%h", v);
    endcase
    return s;
  endfunction

  // Monitor: reset values, bus-source exclusivity, and completion checks against the queue.
  always @(negedge clk) begin
    int   src;
    logic sink;
    exp_t e;
    if (rst) begin
      trace = "";
      check("reset_outputs",
            {13'd0, dp.busy, dp.done, dp.illegal, dp.pc_en, dp.lda, dp.ldb, dp.ldma, dp.ldiR,
             dp.reg_en, dp.reg_we, dp.mem_en, dp.mem_we, dp.alu_en, dp.IMM_en,
             dp.reg_sel, dp.ALUControl, dp.ExtendSign_sel}, 32'd0);
      check("reset_pc", dp.pc, 32'h0);
`ifdef RV_CTRL_INSTR_CNT_EN
      check("reset_retired", dp.retired, 32'd0);
`endif
    end else begin
      src = int'(dp.pc_en) + int'(dp.IMM_en) + int'(dp.alu_en) +
            int'(dp.mem_en & ~dp.mem_we) + int'(dp.reg_en & ~dp.reg_we);
      sink = dp.lda | dp.ldb | dp.ldma | dp.ldiR | dp.reg_we | dp.mem_we;
      checks++;
      assert (src <= 1 && (!sink || src == 1)) else begin
        errors++;
        $display("FAIL bus_source: got %0d sources (sink=%0b) expected exactly one", src, sink);
      end
      if (dp.busy) trace = {trace, cls(), " "};
      if (dp.done) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done with no outstanding instruction, expected none");
        end else begin
          e = q.pop_front();
          checks++;
          if (trace != e.path) begin
            errors++;
            $display("FAIL strobe_sequence: got '%s' expected '%s'", trace, e.path);
          end
          check("latency", cyc - e.acc, e.lat);
          check("pc", dp.pc, e.pc);
          check("illegal", {31'd0, dp.illegal}, {31'd0, e.ill});
          check("busy_in_done", {31'd0, dp.busy}, 32'd0);
`ifdef RV_CTRL_INSTR_CNT_EN
          check("retired", dp.retired, e.ret);
`endif
        end
        trace = "";
      end else if (dp.illegal) begin
        check("illegal_without_done", {31'd0, dp.illegal}, 32'd0);
      end
    end
  end

  task automatic issue(input logic [31:0] ir_v, input logic z, input int gap);
    exp_t        e;
    logic [31:0] np;
    logic        il;
    int          n;
    repeat (gap) begin @(posedge clk); #1; end
    dp.ir = ir_v; dp.zero = z; dp.start = 1'b1;
    model(ir_v, z, mpc, e.path, np, il);
    e.lat = 0;
    for (int k = 0; k < e.path.len(); k++) if (e.path[k] == " ") e.lat++;
    e.pc = np; e.ill = il; e.acc = cyc + 1;
    if (!il) mret = mret + 32'd1;
    e.ret = mret;
    mpc = np;
    q.push_back(e);
    @(posedge clk); #1;
    n = 0;
    // start noise while busy must be ignored
    while (!dp.done && n < 100) begin
      dp.start = ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
      n++;
    end
    dp.start = 1'b0;
    if (!dp.done) begin
      checks++; errors++;
      $display("FAIL timeout: got no done after %0d cycles, expected done", n);
    end
  endtask

  task automatic reset_in_fir();
    dp.ir = 32'h0040A183; dp.zero = 1'b0; dp.start = 1'b1;
    @(posedge clk); #1 dp.start = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_fir", {29'd0, dp.busy, dp.mem_en, dp.ldiR}, 32'd7);
    #1 rst = 1'b1;
    mpc = 32'h0; mret = 32'h0;
    q.delete();
    @(posedge clk); #1 rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_ir();
    logic [31:0] r;
    logic [6:0]  op;
    r = $urandom;
    case ($urandom_range(0, 6))
      0: r[6:0] = 7'b0110011;
      1: r[6:0] = 7'b0010011;
      2: r[6:0] = 7'b0000011;
      3: r[6:0] = 7'b0100011;
      4: begin r[6:0] = 7'b1100011; r[14:12] = 3'($urandom_range(0, 1)); end
      5: begin
        op = 7'b0110011;
        while (op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011 ||
               op == 7'b0100011 || op == 7'b1100011) op = 7'($urandom);
        r[6:0] = op;
      end
      default: ;
    endcase
    return r;
  endfunction

  logic [31:0] dir_ir [14] = '{32'h002081B3, 32'h402081B3, 32'h0020A1B3, 32'h0040A183,
                               32'h00208463, 32'h00208463, 32'h00209463, 32'h0000007F,
                               32'h002091B3, 32'h0030A223, 32'h00108093, 32'h0010E093,
                               32'h0010F093, 32'h40108093};
  logic        dir_z  [14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    dp.start = 1'b0; dp.ir = 32'h0; dp.zero = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 14; i++) issue(dir_ir[i], dir_z[i], (i % 3 == 0) ? 1 : 0);
    reset_in_fir();
    issue(32'hFE000EE3, 1'b1, 1);
    issue(32'h002081B3, 1'b0, 0);
    for (int i = 0; i < 60; i++) issue(rand_ir(), 1'($urandom), $urandom_range(0, 3));
    repeat (5) @(posedge clk);
    check("queue_empty", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
